// File: rtl/tracker_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tracker_pkg
// Purpose  : Shared state, axis and direction encodings for the sun tracker.
// Revision : 1.0 - initial release
// ============================================================================
package tracker_pkg;

    localparam int POS_CENTER = 90;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MEASURE = 3'd1,
        ST_MOVE    = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_SAMPLE  = 3'd4,
        ST_EVAL    = 3'd5,
        ST_HOLD    = 3'd6
    } state_t;

    typedef enum logic {
        AXIS_H = 1'b0,
        AXIS_V = 1'b1
    } axis_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

endpackage
`default_nettype wire

// File: rtl/tracker_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : tracker_sequencer_if
// Purpose  : Panel-voltage ADC request/acknowledge handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface tracker_sequencer_if #(
    parameter int ADC_W = 12
);
    logic             adc_req;
    logic             adc_ack;
    logic [ADC_W-1:0] adc_data;

    modport master (output adc_req, input adc_ack, input adc_data);
    modport slave  (input adc_req, output adc_ack, output adc_data);
endinterface
`default_nettype wire

// File: rtl/tracker_sequencer_settle_timer.sv
`default_nettype none
// ============================================================================
// Module   : settle_timer
// Purpose  : Loadable down-counter; done pulses on the last of load_val cycles.
// Revision : 1.0 - initial release
// ============================================================================
module settle_timer #(
    parameter int CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);
    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (load) begin
            r_cnt <= load_val - c_one;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == '0) r_run <= 1'b0;
            else             r_cnt <= r_cnt - c_one;
        end
    end

    assign done = r_run && (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/tracker_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tracker_sequencer
// Purpose  : Hill-climbing two-axis sun tracker with manual jog fallback.
// Revision : 1.0 - initial release
// ============================================================================
module tracker_sequencer
    import tracker_pkg::*;
#(
    parameter int POS_W      = 8,
    parameter int POS_MIN    = 0,
    parameter int POS_MAX    = 180,
    parameter int STEP       = 2,
    parameter int ADC_W      = 12,
    parameter int HYST       = 8,
    parameter int SETTLE_CYC = 2_000_000,
    parameter int HOLD_CYC   = 100_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 man_l,
    input  logic                 man_r,
    input  logic                 man_u,
    input  logic                 man_d,
    tracker_sequencer_if.master  bus,
    output logic [POS_W-1:0]     pos_h,
    output logic [POS_W-1:0]     pos_v,
    output logic [ADC_W-1:0]     max_v,
    output logic [2:0]           stat,
    output logic                 busy
);
    localparam int c_cnt_w = $clog2(((HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC) + 1);
    localparam logic [POS_W-1:0] c_step       = POS_W'(STEP);
    localparam logic [POS_W-1:0] c_min        = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] c_max        = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] c_center     = POS_W'(POS_CENTER);
    localparam logic [POS_W:0]   c_step_x     = (POS_W+1)'(STEP);
    localparam logic [POS_W:0]   c_max_x      = (POS_W+1)'(POS_MAX);
    localparam logic [POS_W:0]   c_min_step_x = (POS_W+1)'(POS_MIN + STEP);
    localparam logic [ADC_W:0]   c_hyst_x     = (ADC_W+1)'(HYST);

    state_t             r_state, w_next;
    axis_t              r_axis;
    dir_t               r_dir;
    logic               r_miss, r_moved, r_adc_req, r_busy;
    logic [1:0]         r_conv;
    logic [POS_W-1:0]   r_pos_h, r_pos_v;
    logic [ADC_W-1:0]   r_max_v, r_sample;
    logic               w_adc_req, w_busy, w_tmr_load, w_done;
    logic [c_cnt_w-1:0] w_tmr_val;

    // Trial-step arithmetic on the active axis, one extra bit to catch overflow
    logic [POS_W-1:0] w_cur, w_cand, w_undo, w_jog_h, w_jog_v;
    logic [POS_W:0]   w_up, w_h_inc, w_v_inc;
    logic             w_in_range, w_improve, w_other_conv;

    assign w_cur        = (r_axis == AXIS_H) ? r_pos_h : r_pos_v;
    assign w_up         = {1'b0, w_cur} + c_step_x;
    assign w_in_range   = (r_dir == DIR_POS) ? (w_up <= c_max_x) : ({1'b0, w_cur} >= c_min_step_x);
    assign w_cand       = (r_dir == DIR_POS) ? w_up[POS_W-1:0] : (w_cur - c_step);
    assign w_undo       = (r_dir == DIR_POS) ? (w_cur - c_step) : (w_cur + c_step);
    assign w_improve    = r_moved && ({1'b0, r_sample} > ({1'b0, r_max_v} + c_hyst_x));
    assign w_other_conv = (r_axis == AXIS_H) ? r_conv[1] : r_conv[0];

    assign w_h_inc = {1'b0, r_pos_h} + c_step_x;
    assign w_v_inc = {1'b0, r_pos_v} + c_step_x;
    assign w_jog_h = (man_r && !man_l) ? ((w_h_inc > c_max_x) ? c_max : w_h_inc[POS_W-1:0])
                   : (man_l && !man_r) ? (({1'b0, r_pos_h} < c_min_step_x) ? c_min : r_pos_h - c_step)
                   : r_pos_h;
    assign w_jog_v = (man_u && !man_d) ? ((w_v_inc > c_max_x) ? c_max : w_v_inc[POS_W-1:0])
                   : (man_d && !man_u) ? (({1'b0, r_pos_v} < c_min_step_x) ? c_min : r_pos_v - c_step)
                   : r_pos_v;

    settle_timer #(.CNT_W(c_cnt_w)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .done     (w_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_adc_req <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_adc_req <= w_adc_req;
            r_busy    <= w_busy;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!en) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_next = ST_MEASURE;
                ST_MEASURE: if (bus.adc_ack) w_next = ST_MOVE;
                ST_MOVE:    w_next = w_in_range ? ST_SETTLE : ST_EVAL;
                ST_SETTLE:  if (w_done) w_next = ST_SAMPLE;
                ST_SAMPLE:  if (bus.adc_ack) w_next = ST_EVAL;
                ST_EVAL: begin
                    if (!w_improve && r_miss && w_other_conv) w_next = ST_HOLD;
                    else                                      w_next = ST_MOVE;
                end
                ST_HOLD:    if (w_done) w_next = ST_MEASURE;
                default:    w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_adc_req  = (w_next == ST_MEASURE) || (w_next == ST_SAMPLE);
        w_busy     = (w_next != ST_IDLE) && (w_next != ST_HOLD);
        w_tmr_load = ((w_next == ST_SETTLE) && (r_state != ST_SETTLE)) ||
                     ((w_next == ST_HOLD) && (r_state != ST_HOLD));
        w_tmr_val  = (w_next == ST_HOLD) ? c_cnt_w'(HOLD_CYC) : c_cnt_w'(SETTLE_CYC);
    end

    // With en low nothing but jog touches the datapath, so trial steps stay put
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos_h  <= c_center;
            r_pos_v  <= c_center;
            r_max_v  <= '0;
            r_sample <= '0;
            r_axis   <= AXIS_H;
            r_dir    <= DIR_POS;
            r_miss   <= 1'b0;
            r_conv   <= 2'b00;
            r_moved  <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_pos_h <= w_jog_h;
            r_pos_v <= w_jog_v;
            if (en) begin
                r_axis <= AXIS_H;
                r_dir  <= DIR_POS;
                r_miss <= 1'b0;
                r_conv <= 2'b00;
            end
        end else if (en) begin
            case (r_state)
                ST_MEASURE: if (bus.adc_ack) r_max_v <= bus.adc_data;
                ST_MOVE: begin
                    r_moved <= w_in_range;
                    if (w_in_range) begin
                        if (r_axis == AXIS_H) r_pos_h <= w_cand;
                        else                  r_pos_v <= w_cand;
                    end
                end
                ST_SAMPLE: if (bus.adc_ack) r_sample <= bus.adc_data;
                ST_EVAL: begin
                    if (w_improve) begin
                        r_max_v <= r_sample;
                        r_miss  <= 1'b0;
                        r_conv  <= 2'b00;
                    end else begin
                        if (r_moved) begin
                            if (r_axis == AXIS_H) r_pos_h <= w_undo;
                            else                  r_pos_v <= w_undo;
                        end
                        if (r_miss) begin
                            r_conv[r_axis] <= 1'b1;
                            r_axis         <= (r_axis == AXIS_H) ? AXIS_V : AXIS_H;
                            r_miss         <= 1'b0;
                            r_dir          <= DIR_POS;
                        end else begin
                            r_miss <= 1'b1;
                            r_dir  <= (r_dir == DIR_POS) ? DIR_NEG : DIR_POS;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_done) begin
                        r_axis <= AXIS_H;
                        r_dir  <= DIR_POS;
                        r_miss <= 1'b0;
                        r_conv <= 2'b00;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.adc_req = r_adc_req;
    assign pos_h       = r_pos_h;
    assign pos_v       = r_pos_v;
    assign max_v       = r_max_v;
    assign stat        = r_state;
    assign busy        = r_busy;
endmodule
`default_nettype wire
